bg_fetch: RTL and testbench

Pixel-fetch stage between the VGA sync generator and the background image RAM. Each clock it maps the current screen coordinate to a 256x256 image address with 2x scaling and per-frame scrolling. It drives the RAM read port, converts the returned RGB332 byte to RGB444, and delays sync and blank so colour and sync reach the DAC pins aligned.

---
 rtl/bg_fetch.sv | 143 ++++++++++++++
 tb/tb_bg_fetch.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_fetch.sv
// Background pixel fetch: scaled/scrolled RAM addressing, RGB332->RGB444, sync alignment.
// Optional vertical scrolling is enabled by defining BG_VSCROLL_EN.
module bg_fetch #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned V_ACTIVE   = 480
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pixel_tick,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  video_on,
   input  logic                  hsync_i,
   input  logic                  vsync_i,
   input  logic                  scroll_en,
   input  logic                  scroll_dir,
   input  logic [3:0]            scroll_step,
   input  logic                  scroll_load,
   input  logic [7:0]            scroll_init,
   output logic                  sram_en,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   input  logic [DATA_WIDTH-1:0] sram_data,
   output logic [11:0]           rgb,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic [7:0]            scroll_x,
   output logic [7:0]            scroll_y,
   output logic                  frame_tick
);

   localparam int unsigned COORD_W = 10;
   localparam int unsigned OFS_W   = 8;

   logic [OFS_W-1:0] col_c;
   logic [OFS_W-1:0] row_c;
   logic [OFS_W-1:0] step_c;
   logic             frame_evt_c;
   logic             advance_c;
   logic [11:0]      rgb_c;
   logic             unused_c;

   logic von_d1, von_d2;
   logic hs_d1, hs_d2;
   logic vs_d1, vs_d2;

   // 2x downscale of the screen coordinate, then wrap-around offset into the 256x256 image
   assign col_c       = OFS_W'(pixel_x[9:1]) + scroll_x;
   assign row_c       = OFS_W'(pixel_y[9:1]) + scroll_y;
   assign step_c      = OFS_W'(scroll_step);
   assign frame_evt_c = pixel_tick && (pixel_x == '0) && (pixel_y == COORD_W'(V_ACTIVE));
   assign advance_c   = frame_evt_c && scroll_en;
   assign unused_c    = ^{pixel_x[0], pixel_y[0]};

   // Bit replication spreads the 3/3/2-bit channels over the full 4-bit DAC range
   assign rgb_c = {sram_data[7:5], sram_data[7],
                   sram_data[4:2], sram_data[4],
                   sram_data[1:0], sram_data[1:0]};

   function automatic logic [OFS_W-1:0] next_ofs(input logic [OFS_W-1:0] ofs,
                                                input logic              dir,
                                                input logic [OFS_W-1:0] stp);
      next_ofs = dir ? (ofs - stp) : (ofs + stp);
   endfunction

   // Horizontal offset: load beats the frame-event advance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scroll_x <= '0;
      end else if (scroll_load) begin
         scroll_x <= scroll_init;
      end else if (advance_c) begin
         scroll_x <= next_ofs(scroll_x, scroll_dir, step_c);
      end
   end

`ifdef BG_VSCROLL_EN
   // Vertical offset tracks the horizontal rules for diagonal drift
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scroll_y <= '0;
      end else if (scroll_load) begin
         scroll_y <= scroll_init;
      end else if (advance_c) begin
         scroll_y <= next_ofs(scroll_y, scroll_dir, step_c);
      end
   end
`else
   assign scroll_y = '0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_evt_c;
      end
   end

   // Stage 1: RAM address/enable, control delayed once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sram_en   <= 1'b0;
         sram_addr <= '0;
         von_d1    <= 1'b0;
         hs_d1     <= 1'b0;
         vs_d1     <= 1'b0;
      end else begin
         sram_en   <= video_on;
         sram_addr <= ADDR_WIDTH'({row_c, col_c});
         von_d1    <= video_on;
         hs_d1     <= hsync_i;
         vs_d1     <= vsync_i;
      end
   end

   // Stage 2: control waits for RAM read data
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         von_d2 <= 1'b0;
         hs_d2  <= 1'b0;
         vs_d2  <= 1'b0;
      end else begin
         von_d2 <= von_d1;
         hs_d2  <= hs_d1;
         vs_d2  <= vs_d1;
      end
   end

   // Stage 3: colour and sync leave together
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rgb     <= '0;
         hsync_o <= 1'b0;
         vsync_o <= 1'b0;
      end else begin
         rgb     <= von_d2 ? rgb_c : 12'h000;
         hsync_o <= hs_d2;
         vsync_o <= vs_d2;
      end
   end

endmodule

// File: tb/tb_bg_fetch.sv
// Self-checking bench for bg_fetch: directed vector table, scroll corner sequences,
// randomized traffic against an arithmetic reference model.
module tb_bg_fetch;

`ifdef BG_VSCROLL_EN
   localparam bit VS = 1'b1;
`else
   localparam bit VS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        pixel_tick, video_on, hsync_i, vsync_i;
   logic [9:0]  pixel_x, pixel_y;
   logic        scroll_en, scroll_dir, scroll_load;
   logic [3:0]  scroll_step;
   logic [7:0]  scroll_init;
   logic        sram_en;
   logic [15:0] sram_addr;
   logic [7:0]  sram_data;
   logic [11:0] rgb;
   logic        hsync_o, vsync_o, frame_tick;
   logic [7:0]  scroll_x, scroll_y;

   logic [7:0]  mem [65536];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0]  sinit;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [7:0]  d;
      logic [15:0] addr;
      logic [11:0] rgb;
   } vec_t;

   typedef struct {
      int rgb;
      int hs;
      int vs;
   } exp_t;

   vec_t tbl [5];
   exp_t q[$];

   bg_fetch dut (
      .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .scroll_en(scroll_en),
      .scroll_dir(scroll_dir), .scroll_step(scroll_step),
      .scroll_load(scroll_load), .scroll_init(scroll_init),
      .sram_en(sram_en), .sram_addr(sram_addr), .sram_data(sram_data),
      .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o),
      .scroll_x(scroll_x), .scroll_y(scroll_y), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data one clk after address
   always @(posedge clk) sram_data <= mem[sram_addr];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pixel_tick = 0; pixel_x = 0; pixel_y = 0; video_on = 0;
      hsync_i = 0; vsync_i = 0; scroll_en = 0; scroll_dir = 0;
      scroll_step = 0; scroll_load = 0; scroll_init = 0;
   endtask

   task automatic load(input logic [7:0] v);
      idle();
      scroll_load = 1; scroll_init = v;
      step();
      scroll_load = 0;
   endtask

   task automatic frame_evt(input logic en, input logic dir, input logic [3:0] stp,
                            input logic ld, input logic [7:0] init);
      idle();
      pixel_tick = 1; pixel_x = 0; pixel_y = 10'd480;
      scroll_en = en; scroll_dir = dir; scroll_step = stp;
      scroll_load = ld; scroll_init = init;
      step();
      idle();
   endtask

   function automatic int conv(input int d);
      int r3, g3, b2;
      r3 = d / 32;
      g3 = (d / 4) % 8;
      b2 = d % 4;
      return ((r3 * 2 + r3 / 4) * 256) + ((g3 * 2 + g3 / 4) * 16) + (b2 * 5);
   endfunction

   initial begin
      int msx, msy, ex_addr, evt, ld, dir, stp, init, en;
      exp_t e;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      idle();
      reset_n = 0;

      // Reset values
      step(); step();
      check("rst_sram_en", int'(sram_en), 0);
      check("rst_sram_addr", int'(sram_addr), 0);
      check("rst_rgb", int'(rgb), 0);
      check("rst_hsync_o", int'(hsync_o), 0);
      check("rst_vsync_o", int'(vsync_o), 0);
      check("rst_scroll_x", int'(scroll_x), 0);
      check("rst_scroll_y", int'(scroll_y), 0);
      check("rst_frame_tick", int'(frame_tick), 0);
      reset_n = 1;

      // Directed vectors: offset load, one pixel, address and colour
      tbl[0] = '{8'h00, 10'd0,   10'd0,   8'hE0, 16'h0000, 12'hF00};
      tbl[1] = '{8'h00, 10'd639, 10'd479, 8'h1C, 16'hEF3F, 12'h0F0};
      tbl[2] = '{8'h00, 10'd639, 10'd479, 8'h03, 16'hEF3F, 12'h00F};
      tbl[3] = '{8'd250, 10'd20, 10'd0,   8'hFF, VS ? 16'hFA04 : 16'h0004, 12'hFFF};
      tbl[4] = '{8'h10, 10'd100, 10'd50,  8'hA5, VS ? 16'h2942 : 16'h1942, 12'hB25};
      for (int i = 0; i < 5; i++) begin
         load(tbl[i].sinit);
         mem[tbl[i].addr] = tbl[i].d;
         pixel_x = tbl[i].x; pixel_y = tbl[i].y; video_on = 1;
         step();
         check($sformatf("vec%0d_addr", i), int'(sram_addr), int'(tbl[i].addr));
         check($sformatf("vec%0d_en", i), int'(sram_en), 1);
         video_on = 0;
         step(); step();
         check($sformatf("vec%0d_rgb", i), int'(rgb), int'(tbl[i].rgb));
      end

      // Decrement wrap 2 - 5 -> 253
      load(8'd2);
      frame_evt(1, 1, 4'd5, 0, 8'd0);
      check("wrapdn_x", int'(scroll_x), 253);
      check("wrapdn_y", int'(scroll_y), VS ? 253 : 0);
      check("wrapdn_ft", int'(frame_tick), 1);
      step();
      check("ft_one_clk", int'(frame_tick), 0);

      // Increment wrap 255 + 1 -> 0
      load(8'd255);
      frame_evt(1, 0, 4'd1, 0, 8'd0);
      check("wrapup_x", int'(scroll_x), 0);

      // Load beats a simultaneous frame event
      load(8'd7);
      frame_evt(1, 0, 4'd3, 1, 8'h80);
      check("ldevt_x", int'(scroll_x), 8'h80);
      check("ldevt_y", int'(scroll_y), VS ? 8'h80 : 0);
      check("ldevt_ft", int'(frame_tick), 1);

      // Zero step still ticks, offsets unchanged
      frame_evt(1, 0, 4'd0, 0, 8'd0);
      check("step0_x", int'(scroll_x), 8'h80);
      check("step0_ft", int'(frame_tick), 1);

      // Event with scroll disabled holds offsets
      frame_evt(0, 0, 4'd9, 0, 8'd0);
      check("noen_x", int'(scroll_x), 8'h80);

      // Blanking: no RAM enable, black output despite nonzero data
      load(8'd0);
      mem[16'h0505] = 8'hFF;
      pixel_x = 10; pixel_y = 10; video_on = 0;
      step();
      check("blank_en", int'(sram_en), 0);
      check("blank_addr", int'(sram_addr), 16'h0505);
      idle();
      step(); step();
      check("blank_rgb", int'(rgb), 0);

      // Randomized run against the reference model, from a fresh reset
      reset_n = 0;
      step();
      reset_n = 1;
      msx = 0; msy = 0;
      q.delete();
      e = '{0, 0, 0};
      q.push_back(e); q.push_back(e);
      for (int c = 0; c < 1500; c++) begin
         idle();
         if ($urandom_range(0, 5) == 0) begin
            pixel_x = 0; pixel_y = 10'd480;
         end else begin
            pixel_x = 10'($urandom_range(0, 639)); pixel_y = 10'($urandom_range(0, 524));
         end
         pixel_tick = 1'($urandom); video_on = 1'($urandom);
         hsync_i = 1'($urandom); vsync_i = 1'($urandom);
         scroll_en = 1'($urandom); scroll_dir = 1'($urandom);
         scroll_step = 4'($urandom); scroll_init = 8'($urandom);
         scroll_load = ($urandom_range(0, 15) == 0);

         evt = (pixel_tick && pixel_x == 0 && pixel_y == 480) ? 1 : 0;
         ex_addr = (((int'(pixel_y) / 2 + msy) % 256) * 256) + ((int'(pixel_x) / 2 + msx) % 256);
         e.rgb = video_on ? conv(int'(mem[ex_addr])) : 0;
         e.hs = int'(hsync_i); e.vs = int'(vsync_i);
         q.push_back(e);

         ld = int'(scroll_load); en = int'(scroll_en); dir = int'(scroll_dir);
         stp = int'(scroll_step); init = int'(scroll_init);
         if (ld != 0) begin
            msx = init;
            msy = VS ? init : 0;
         end else if (evt != 0 && en != 0) begin
            msx = (msx + (dir != 0 ? 256 - stp : stp)) % 256;
            if (VS) msy = (msy + (dir != 0 ? 256 - stp : stp)) % 256;
         end

         step();
         check("rnd_addr", int'(sram_addr), ex_addr);
         check("rnd_en", int'(sram_en), int'(video_on));
         check("rnd_ft", int'(frame_tick), evt);
         check("rnd_sx", int'(scroll_x), msx);
         check("rnd_sy", int'(scroll_y), msy);
         check("rnd_rgb", int'(rgb), q[q.size() - 3].rgb);
         check("rnd_hs", int'(hsync_o), q[q.size() - 3].hs);
         check("rnd_vs", int'(vsync_o), q[q.size() - 3].vs);
         if (q.size() > 3) void'(q.pop_front());
      end

      // Asynchronous reset mid-line clears outputs before the next edge
      load(8'h55);
      mem[VS ? 16'h8787 : 16'h3287] = 8'hFF;
      pixel_x = 100; pixel_y = 100; video_on = 1; hsync_i = 1; vsync_i = 1;
      step(); step(); step(); step();
      check("pre_rst_rgb", int'(rgb), 12'hFFF);
      check("pre_rst_hs", int'(hsync_o), 1);
      #2;
      reset_n = 0;
      #1;
      check("async_rgb", int'(rgb), 0);
      check("async_hs", int'(hsync_o), 0);
      check("async_vs", int'(vsync_o), 0);
      check("async_sx", int'(scroll_x), 0);
      check("async_sy", int'(scroll_y), 0);
      check("async_en", int'(sram_en), 0);
      step();
      reset_n = 1;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
